// File: rtl/bt_ac_pkg.sv
// Shared BR/EDR access-code constants and the transmit FSM state type.
`timescale 1ns/1ps
package bt_ac_pkg;

    localparam int unsigned PRE_LEN   = 4;
    localparam int unsigned SYNC_LEN  = 64;
    localparam int unsigned TRL_LEN   = 4;

    localparam int unsigned DLY_CNT_W = 8;
    localparam int unsigned BIT_CNT_W = 7;

    typedef enum logic [2:0] {
        AC_IDLE = 3'd0,
        AC_DLY  = 3'd1,
        AC_PRE  = 3'd2,
        AC_SYNC = 3'd3,
        AC_TRL  = 3'd4
    } ac_tx_state_t;

endpackage

// File: rtl/access_code_tx.sv
// Access-code transmitter: after a programmable delay, serialises preamble,
// sync word and optional trailer LSB-first, one bit per 1 us strobe.
`timescale 1ns/1ps
module access_code_tx #(
    parameter int unsigned PRE_LEN  = bt_ac_pkg::PRE_LEN,
    parameter int unsigned SYNC_LEN = bt_ac_pkg::SYNC_LEN,
    parameter int unsigned TRL_LEN  = bt_ac_pkg::TRL_LEN
) (
    input  logic                clk_6M,
    input  logic                rstz,
    input  logic                p_1us,
    input  logic                tx_start_p,
    input  logic                abort_p,
    input  logic [SYNC_LEN-1:0] sync_word,
    input  logic                with_trailer,
    input  logic [7:0]          regi_txdly,
    output logic                tx_bit,
    output logic                tx_en,
    output logic                tx_busy,
    output logic                sync_end_p,
    output logic                ac_done_p
);
    import bt_ac_pkg::*;

    localparam logic [BIT_CNT_W-1:0] PRE_LAST  = BIT_CNT_W'(PRE_LEN - 1);
    localparam logic [BIT_CNT_W-1:0] SYNC_LAST = BIT_CNT_W'(SYNC_LEN - 1);
    localparam logic [BIT_CNT_W-1:0] TRL_LAST  = BIT_CNT_W'(TRL_LEN - 1);

    ac_tx_state_t               state, state_nxt;
    logic [DLY_CNT_W-1:0]       dly_cnt, dly_cnt_nxt;
    logic [BIT_CNT_W-1:0]       bit_cnt, bit_cnt_nxt;
    logic [SYNC_LEN-1:0]        shreg, shreg_nxt;
    logic                       trl_en, trl_en_nxt;
    logic                       bit_nxt, en_nxt, busy_nxt;
    logic                       sync_end_nxt, ac_done_nxt;
    logic                       raw_bit;

    // State and output registers
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state      <= AC_IDLE;
            dly_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            trl_en     <= 1'b0;
            tx_bit     <= 1'b0;
            tx_en      <= 1'b0;
            tx_busy    <= 1'b0;
            sync_end_p <= 1'b0;
            ac_done_p  <= 1'b0;
        end else begin
            state      <= state_nxt;
            dly_cnt    <= dly_cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shreg      <= shreg_nxt;
            trl_en     <= trl_en_nxt;
            tx_bit     <= bit_nxt;
            tx_en      <= en_nxt;
            tx_busy    <= busy_nxt;
            sync_end_p <= sync_end_nxt;
            ac_done_p  <= ac_done_nxt;
        end
    end

    // Next state and next output values; bits only advance on p_1us
    always_comb begin
        state_nxt    = state;
        dly_cnt_nxt  = dly_cnt;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        trl_en_nxt   = trl_en;
        raw_bit      = tx_bit;
        en_nxt       = tx_en;
        sync_end_nxt = 1'b0;
        ac_done_nxt  = 1'b0;

        if (abort_p) begin
            state_nxt = AC_IDLE;
            en_nxt    = 1'b0;
        end else begin
            case (state)
                AC_IDLE: begin
                    if (tx_start_p) begin
                        shreg_nxt   = sync_word;
                        trl_en_nxt  = with_trailer;
                        dly_cnt_nxt = regi_txdly;
                        bit_cnt_nxt = '0;
                        state_nxt   = AC_DLY;
                    end
                end
                AC_DLY: begin
                    if (p_1us) begin
                        if (dly_cnt == '0) begin
                            state_nxt   = AC_PRE;
                            bit_cnt_nxt = '0;
                            en_nxt      = 1'b1;
                            raw_bit     = shreg[0];
                        end else begin
                            dly_cnt_nxt = dly_cnt - DLY_CNT_W'(1);
                        end
                    end
                end
                AC_PRE: begin
                    // Preamble alternates starting from s0: even bits s0, odd bits ~s0
                    if (p_1us) begin
                        if (bit_cnt == PRE_LAST) begin
                            state_nxt   = AC_SYNC;
                            bit_cnt_nxt = '0;
                            raw_bit     = shreg[0];
                        end else begin
                            bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
                            raw_bit     = shreg[0] ^ ~bit_cnt[0];
                        end
                    end
                end
                AC_SYNC: begin
                    if (p_1us) begin
                        if (bit_cnt == SYNC_LAST) begin
                            sync_end_nxt = 1'b1;
                            if (trl_en) begin
                                // shreg[0] now holds s63; trailer starts with ~s63
                                state_nxt   = AC_TRL;
                                bit_cnt_nxt = '0;
                                raw_bit     = ~shreg[0];
                            end else begin
                                state_nxt   = AC_IDLE;
                                en_nxt      = 1'b0;
                                ac_done_nxt = 1'b1;
                            end
                        end else begin
                            shreg_nxt   = shreg >> 1;
                            raw_bit     = shreg[1];
                            bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                end
                AC_TRL: begin
                    if (p_1us) begin
                        if (bit_cnt == TRL_LAST) begin
                            state_nxt   = AC_IDLE;
                            en_nxt      = 1'b0;
                            ac_done_nxt = 1'b1;
                        end else begin
                            bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
                            raw_bit     = shreg[0] ^ bit_cnt[0];
                        end
                    end
                end
                default: begin
                    state_nxt = AC_IDLE;
                    en_nxt    = 1'b0;
                end
            endcase
        end

        bit_nxt  = raw_bit & en_nxt;
        busy_nxt = (state_nxt != AC_IDLE);
    end

endmodule
